// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU definitions: flag bit order and sequencer states
// Used by every ALU op (LSR, LSL, ADD, ...) so all agree on the [N,Z,C,V] layout.
package alu_pkg;

  // Flag vector bit positions, bit3..bit0 = N,Z,C,V
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Multi-cycle op sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/lsl_flag_gen.sv
// rtl/lsl_flag_gen.sv - combinational [N,Z,C,V] generator for shift ops
// Ports:
//   acc      in  WIDTH  final shifted value
//   c_reg    in  1      last bit shifted out (or carried-in C when no shift)
//   s        in  1      1 = compute new flags, 0 = pass flag_lat through
//   flag_lat in  4      flags latched at operation start
//   flag     out 4      resulting flag vector
module lsl_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             c_reg,
  input  logic             s,
  input  logic [3:0]       flag_lat,
  output logic [3:0]       flag
);

  always_comb begin
    flag = flag_lat;
    if (s) begin
      flag[FLG_N] = acc[WIDTH-1];
      flag[FLG_Z] = (acc == '0);
      flag[FLG_C] = c_reg;
      // V is never touched by a shift
    end
  end

endmodule

// File: rtl/lsl_seq.sv
// rtl/lsl_seq.sv - multi-cycle logical shift left, one bit per clock, with flags
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      asynchronous active-low reset
//   start    in  1      request pulse, sampled only in IDLE
//   in1      in  WIDTH  operand
//   in2      in  SH_W   shift amount
//   s        in  1      flag-update enable
//   flag_in  in  4      current flags [N,Z,C,V]
//   busy     out 1      accept edge .. DONE-exit edge
//   done     out 1      one-cycle completion pulse
//   result   out WIDTH  shifted value, held until next completion
//   new_flag out 4      updated flags, held like result
module lsl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [SH_W-1:0]  in2,
  input  logic             s,
  input  logic [3:0]       flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       new_flag
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             s_q, s_d;
  logic [3:0]       flg_q, flg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       new_flag_q, new_flag_d;
  logic [3:0]       gen_flag;

  lsl_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .acc      (acc_q),
    .c_reg    (c_q),
    .s        (s_q),
    .flag_lat (flg_q),
    .flag     (gen_flag)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    s_d        = s_q;
    flg_d      = flg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    new_flag_d = new_flag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = in1;
          cnt_d   = in2;
          // Seeding with the incoming C makes a zero-length shift keep C
          c_d     = flag_in[FLG_C];
          s_d     = s;
          flg_d   = flag_in;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = {acc_q[WIDTH-2:0], 1'b0};
          c_d   = acc_q[WIDTH-1];
          cnt_d = cnt_q - SH_W'(1);
        end else begin
          result_d   = acc_q;
          new_flag_d = gen_flag;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      s_q        <= 1'b0;
      flg_q      <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      new_flag_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      s_q        <= s_d;
      flg_q      <= flg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      new_flag_q <= new_flag_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign new_flag = new_flag_q;

  // Shifts longer than the operand are only reachable with a widened SH_W
  a_shift_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && start) |-> (int'(in2) <= WIDTH));

endmodule

// File: doc/lsl_seq.md
Name: lsl_seq

Overview:
- Multi-cycle logical-shift-left ALU unit. It is the left-shift counterpart of the combinational LSR unit.
- Shifts a WIDTH-bit operand left by a SH_W-bit amount, one bit position per clock.
- Produces condition flags [N,Z,C,V] with the same S-gated update rule as the rest of the ALU.
- Sits beside the other ALU ops. Uses a start/busy/done handshake so the control FSM can issue a shift and wait for completion.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SH_W, 4, shift-amount width; maximum shift is 2^SH_W-1 (15 by default).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- in1  input  WIDTH  operand to shift.
- in2  input  SH_W  shift amount.
- s  input  1  flag-update enable (1 = compute new flags, 0 = pass flag_in through).
- flag_in  input  4  current flags [N,Z,C,V] (bit3..bit0).
- busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
- done  output  1  one-cycle pulse; result and new_flag are valid from this cycle on.
- result  output  WIDTH  shifted value; held until the next accepted operation.
- new_flag  output  4  updated flags [N,Z,C,V]; held like result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy=0, done=0, result=0, new_flag=0000. Internal acc, cnt and carry are cleared. An in-flight operation is aborted and no done pulse is emitted.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - acc<=in1, cnt<=in2, c_reg<=flag_in[1].
  - s and flag_in are latched.
  - state<=SHIFT, busy<=1.
- SHIFT, cnt!=0 at an edge: acc<=acc<<1 (zero fill), c_reg<=acc[WIDTH-1], cnt<=cnt-1.
- SHIFT, cnt==0 at an edge:
  - result<=acc.
  - new_flag computed per the flag rules below.
  - state<=DONE, done<=1.
- DONE at the next edge: done<=0, busy<=0, state<=IDLE.
- A new start can be accepted at the edge after DONE, i.e. with the controller's start held high the bubble is one cycle.
- Latency: done is high in the cycle after in2+2 edges following the accepting edge, counting that edge. For in2=0 the pulse appears 2 edges after acceptance.
- Flags when the latched s=1:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - C = last bit shifted out; C = latched flag_in C when in2=0.
  - V = latched flag_in V, unchanged.
- Flags when the latched s=0: new_flag = latched flag_in. result is still updated.
- start while busy=1 is ignored. Operands are not re-sampled and there is no error.
- in1/in2/flag_in/s may change freely after acceptance with no effect on the operation.
- Shifts at or beyond WIDTH cannot occur at defaults (SH_W=4). If SH_W is raised so that in2>=WIDTH, result=0 and C=original in1 bit (in2==WIDTH ? 0 : none); such shifts are unsupported above WIDTH and flagged by an assertion.
- result/new_flag never change except at the SHIFT->DONE edge or on reset.

Decomposition:
- Shared package alu_pkg:
  - Flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
  - State enum {IDLE, SHIFT, DONE}.
  - Used by all ALU ops so LSR/LSL/ADD agree on flag order.
- One sub-module: lsl_flag_gen (combinational). Inputs: acc, c_reg, s, latched flags. Output: 4-bit flag vector. Reusable by LSR.

Test Plan:
- in1=3, in2=1, s=1, flag_in=0000 -> result=6, new_flag=0000. done 3 edges after acceptance, busy high in between.
- in1=32'h80000001, in2=1, s=1, flag_in=0000 -> result=32'h00000002, new_flag=0010 (C=1).
- in1=32'hFFFFFFFF, in2=9, s=1, flag_in=0001 -> result=32'hFFFFFE00, new_flag=1011 (N=1, C=1, V kept). done 11 edges after acceptance.
- in1=-6 (32'hFFFFFFFA), in2=4, s=0, flag_in=0101 -> result=32'hFFFFFFA0, new_flag=0101 unchanged.
- in1=0, in2=0, s=1, flag_in=0011 -> result=0, new_flag=0111 (Z=1, C and V kept). done 2 edges after acceptance.
- in1=1, in2=15 accepted; second start with in1=7 pulsed 2 cycles later; rst_n pulsed low mid-shift on a third run:
  - First op gives result=32'h00008000; the second start is ignored.
  - On the reset run, outputs go to 0/0000 immediately with no done pulse.
  - The next start after reset completes normally.
